// File: rtl/spart_rx_fifo_if.sv
// Bundle between the SPART receiver / processor side and the receive FIFO.
// master drives bytes, handshake and pops; slave is the FIFO.
interface spart_rx_fifo_if #(
    parameter int unsigned AW = 4
);
    logic [7:0]  rx_data;
    logic        rda;
    logic        clr_rda;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;
    logic        clr_ovr;

    modport master (
        output rx_data, rda, rd_en, clr_ovr,
        input  clr_rda, rd_data, empty, full, count, overrun
    );

    modport slave (
        input  rx_data, rda, rd_en, clr_ovr,
        output clr_rda, rd_data, empty, full, count, overrun
    );
endinterface

// File: rtl/spart_rx_fifo.sv
// Receive FIFO for the SPART: acknowledges each byte from the receiver with a one-cycle
// clr_rda pulse, buffers it, and presents the head entry first-word-fall-through.
module spart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input logic           clk,
    input logic           rst,
    spart_rx_fifo_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAck, StWaitLow} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          clr_rda_q, clr_rda_d;
    logic          empty, full, capture, push, pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop     = bus.rd_en && !empty;
    assign capture = (state_q == StIdle) && bus.rda;
    // A same-cycle pop frees the slot, so a capture while full is still accepted.
    assign push    = capture && (!full || pop);

    always_comb begin
        state_d   = state_q;
        clr_rda_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.rda) begin
                    state_d   = StAck;
                    clr_rda_d = 1'b1;
                end
            end
            StAck:     state_d = StWaitLow;
            StWaitLow: if (!bus.rda) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

        overrun_d = overrun_q;
        if (capture && !push) begin
            overrun_d = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            clr_rda_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            clr_rda_q <= clr_rda_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rd_data = mem[rd_ptr_q];
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.overrun = overrun_q;
    assign bus.clr_rda = clr_rda_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Self-checking bench for spart_rx_fifo: a queue-based model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_spart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spart_rx_fifo_if #(.AW(AW)) bus ();

    spart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: stored bytes, sticky flag, expected ack, and whether the receiver handshake is free.
    byte unsigned mq[$];
    bit m_ovr     = 1'b0;
    bit m_ack     = 1'b0;
    bit hs_free   = 1'b1;
    int since_cap = 0;
    bit m_pop, m_cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovr     = 1'b0;
            m_ack     = 1'b0;
            hs_free   = 1'b1;
            since_cap = 0;
        end else begin
            m_pop = bus.rd_en && (mq.size() > 0);
            m_cap = bus.rda && hs_free;
            if (m_pop) void'(mq.pop_front());
            if (m_cap && mq.size() >= DEPTH) begin
                m_ovr = 1'b1;
            end else begin
                if (m_cap) mq.push_back(bus.rx_data);
                if (bus.clr_ovr) m_ovr = 1'b0;
            end
            m_ack = m_cap;
            // A new byte is only taken once rda has been seen low after the ack cycle.
            if (m_cap) begin
                hs_free   = 1'b0;
                since_cap = 0;
            end else if (!hs_free) begin
                since_cap++;
                if (since_cap >= 2 && !bus.rda) hs_free = 1'b1;
            end
        end
        #1;
        chk("m_count",   32'(bus.count),   32'(mq.size()));
        chk("m_empty",   32'(bus.empty),   32'(mq.size() == 0));
        chk("m_full",    32'(bus.full),    32'(mq.size() == DEPTH));
        chk("m_overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("m_clr_rda", 32'(bus.clr_rda), 32'(m_ack));
        if (mq.size() > 0) chk("m_rd_data", 32'(bus.rd_data), 32'(mq[0]));
    end

    // Receiver model: raise rda, wait for the ack, hold rda for extra cycles, then drop it.
    task automatic send(input logic [7:0] b, input int hold);
        int n = 0;
        @(negedge clk);
        bus.rx_data = b;
        bus.rda     = 1'b1;
        @(negedge clk);
        while (bus.clr_rda !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ack_seen", 32'(bus.clr_rda), 32'd1);
        repeat (hold) @(negedge clk);
        bus.rda = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop(input logic [7:0] exp, input string name);
        @(negedge clk);
        chk(name, 32'(bus.rd_data), 32'(exp));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_data = 8'h00;
        bus.rda     = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_ovr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty",   32'(bus.empty),   32'd1);
        chk("rst_count",   32'(bus.count),   32'd0);
        chk("rst_full",    32'(bus.full),    32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_clr_rda", 32'(bus.clr_rda), 32'd0);

        // Single byte
        send(8'h5A, 0);
        chk("single_count", 32'(bus.count),   32'd1);
        chk("single_data",  32'(bus.rd_data), 32'h5A);
        pop(8'h5A, "single_pop");
        chk("single_empty", 32'(bus.empty), 32'd1);

        // Pop while empty is ignored
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("empty_pop_count", 32'(bus.count),   32'd0);
        chk("empty_pop_ovr",   32'(bus.overrun), 32'd0);

        // Fill and overrun
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        send(8'hAA, 0);
        chk("ovr_set",   32'(bus.overrun), 32'd1);
        chk("ovr_count", 32'(bus.count),   32'd16);
        for (int i = 0; i < 16; i++) pop(8'(i), "fill_order");
        chk("fill_drained", 32'(bus.empty), 32'd1);

        // Clear overrun
        @(negedge clk);
        bus.clr_ovr = 1'b1;
        @(negedge clk);
        bus.clr_ovr = 1'b0;
        chk("ovr_clear", 32'(bus.overrun), 32'd0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) send(8'(8'h10 + i), 0);
        for (int i = 0; i < 10; i++) pop(8'(8'h10 + i), "wrap_a");
        for (int i = 0; i < 12; i++) send(8'(8'h20 + i), 0);
        for (int i = 0; i < 12; i++) pop(8'(8'h20 + i), "wrap_b");
        chk("wrap_count", 32'(bus.count), 32'd0);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Slow rda: one capture only
        send(8'h66, 5);
        chk("slow_count", 32'(bus.count), 32'd1);
        pop(8'h66, "slow_pop");

        // Capture and pop together while full
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 0);
        @(negedge clk);
        bus.rx_data = 8'h77;
        bus.rda     = 1'b1;
        bus.rd_en   = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("sim_ack", 32'(bus.clr_rda), 32'd1);
        bus.rda = 1'b0;
        repeat (2) @(negedge clk);
        chk("sim_count", 32'(bus.count),   32'd16);
        chk("sim_ovr",   32'(bus.overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop(8'(8'h30 + i), "sim_order");
        pop(8'h77, "sim_last");

        // Async reset in the ack cycle with three bytes stored
        send(8'h01, 0);
        send(8'h02, 0);
        @(negedge clk);
        bus.rx_data = 8'h03;
        bus.rda     = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_rst_ack",   32'(bus.clr_rda), 32'd1);
        chk("pre_rst_count", 32'(bus.count),   32'd3);
        rst = 1'b1;
        #1;
        chk("arst_count",   32'(bus.count),   32'd0);
        chk("arst_empty",   32'(bus.empty),   32'd1);
        chk("arst_full",    32'(bus.full),    32'd0);
        chk("arst_overrun", 32'(bus.overrun), 32'd0);
        chk("arst_clr_rda", 32'(bus.clr_rda), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack",   32'(bus.clr_rda), 32'd1);
        chk("post_rst_count", 32'(bus.count),   32'd1);
        chk("post_rst_data",  32'(bus.rd_data), 32'h03);
        bus.rda = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_once", 32'(bus.count), 32'd1);
        pop(8'h03, "post_rst_pop");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
